// File: rtl/mpy_retire_pkg.sv
// Shared CPU definitions used by the multiply retire stage:
// the flag bit positions and the default register tag width.
package mpy_retire_pkg;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_C = 3;

  localparam int CPU_REGW = 5;

endpackage

// File: rtl/mpy_sfifo.sv
// Synchronous FIFO with a registered first-word-fall-through head.
// A word pushed into an empty FIFO becomes visible on the following cycle.
module mpy_sfifo #(
  parameter int LGDEPTH = 2,
  parameter int WIDTH   = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  localparam int DEPTH = 1 << LGDEPTH;
  localparam logic [LGDEPTH-1:0] PTR_ONE = 1;
  localparam logic [LGDEPTH:0]   CNT_ONE = 1;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [LGDEPTH-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [LGDEPTH:0]   count_reg, count_next;
  logic [WIDTH-1:0]   head_reg;
  logic               valid_reg;
  logic               push, pop;

  assign pop         = i_pop && valid_reg;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push        = i_push && (!count_reg[LGDEPTH] || pop);
  assign rd_ptr_next = pop ? rd_ptr_reg + PTR_ONE : rd_ptr_reg;

  always_comb begin
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + CNT_ONE;
    else if (!push && pop)
      count_next = count_reg - CNT_ONE;
  end

  always_ff @(posedge i_clk) begin
    if (push)
      mem[wr_ptr_reg] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      valid_reg  <= 1'b0;
      head_reg   <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      valid_reg  <= (count_next != '0);
      // Bypass the array when the incoming word is the next head.
      if (push && (wr_ptr_reg == rd_ptr_next))
        head_reg <= i_data;
      else
        head_reg <= mem[rd_ptr_next];
    end
  end

  assign o_valid = valid_reg;
  assign o_data  = head_reg;

endmodule

// File: rtl/mpy_retire.sv
// Retire stage behind the multiplier: pairs issue-time register tags with
// products, selects the result half, computes flags and buffers for writeback.
module mpy_retire
  import mpy_retire_pkg::*;
#(
  parameter int LGDEPTH      = 2,
  parameter int REGW         = CPU_REGW,
  parameter bit OPT_LOWPOWER = 1'b0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_issue,
  input  logic [REGW-1:0] i_reg,
  output logic            o_issue_ready,
  input  logic            i_mpy_valid,
  input  logic [63:0]     i_mpy_result,
  input  logic            i_mpy_hi,
  output logic            o_wb_valid,
  input  logic            i_wb_ready,
  output logic [REGW-1:0] o_wb_reg,
  output logic [31:0]     o_wb_data,
  output logic [3:0]      o_wb_flags,
  output logic            o_err
);

  localparam int RESW = REGW + 34;
  localparam logic [LGDEPTH:0] CNT_ONE = 1;

  logic [LGDEPTH:0] outstanding_reg;
  logic             issue_ok, wb_hs, mpy_ok;
  logic             tag_valid, res_valid;
  logic [REGW-1:0]  tag_head;
  logic [31:0]      sel;
  logic [RESW-1:0]  res_in, res_head;
  logic [3:0]       flags;
  logic             err_reg;

  // Outstanding never exceeds 2^LGDEPTH, so the top bit alone means "full".
  assign o_issue_ready = !outstanding_reg[LGDEPTH];
  assign issue_ok      = i_issue && o_issue_ready;
  assign wb_hs         = res_valid && i_wb_ready;
  assign mpy_ok        = i_mpy_valid && tag_valid;

  always_ff @(posedge i_clk) begin
    if (i_reset)
      outstanding_reg <= '0;
    else if (issue_ok && !wb_hs)
      outstanding_reg <= outstanding_reg + CNT_ONE;
    else if (!issue_ok && wb_hs)
      outstanding_reg <= outstanding_reg - CNT_ONE;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)
      err_reg <= 1'b0;
    else if ((i_issue && !o_issue_ready) || (i_mpy_valid && !tag_valid))
      err_reg <= 1'b1;
  end

  mpy_sfifo #(.LGDEPTH(LGDEPTH), .WIDTH(REGW)) u_tag_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (issue_ok),
    .i_data  (i_reg),
    .i_pop   (mpy_ok),
    .o_valid (tag_valid),
    .o_data  (tag_head)
  );

  assign sel    = i_mpy_hi ? i_mpy_result[63:32] : i_mpy_result[31:0];
  assign res_in = {tag_head, sel, sel[31], (sel == 32'd0)};

  mpy_sfifo #(.LGDEPTH(LGDEPTH), .WIDTH(RESW)) u_res_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (mpy_ok),
    .i_data  (res_in),
    .i_pop   (wb_hs),
    .o_valid (res_valid),
    .o_data  (res_head)
  );

  // Carry and overflow are never produced by a multiply.
  always_comb begin
    flags         = '0;
    flags[FLAG_N] = res_head[1];
    flags[FLAG_Z] = res_head[0];
  end

  assign o_wb_valid = res_valid;
  assign o_wb_reg   = (OPT_LOWPOWER && !res_valid) ? '0 : res_head[RESW-1:34];
  assign o_wb_data  = (OPT_LOWPOWER && !res_valid) ? '0 : res_head[33:2];
  assign o_wb_flags = (OPT_LOWPOWER && !res_valid) ? '0 : flags;
  assign o_err      = err_reg;

endmodule

// File: tb/tb_mpy_retire.sv
// Self-checking bench for mpy_retire: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_mpy_retire;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        issue = 1'b0;
  logic [4:0]  reg_in = '0;
  logic        mv = 1'b0;
  logic [63:0] result = '0;
  logic        hi = 1'b0;
  logic        wb_ready = 1'b0;
  logic        issue_ready, wb_valid, err;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic [3:0]  wb_flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mpy_retire #(.LGDEPTH(2), .REGW(5), .OPT_LOWPOWER(1'b1)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_issue       (issue),
    .i_reg         (reg_in),
    .o_issue_ready (issue_ready),
    .i_mpy_valid   (mv),
    .i_mpy_result  (result),
    .i_mpy_hi      (hi),
    .o_wb_valid    (wb_valid),
    .i_wb_ready    (wb_ready),
    .o_wb_reg      (wb_reg),
    .o_wb_data     (wb_data),
    .o_wb_flags    (wb_flags),
    .o_err         (err)
  );

  // Reference model: tags awaiting products, completed results awaiting writeback.
  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
    logic [3:0]  f;
  } res_t;

  logic [4:0] m_tags[$];
  res_t       m_res[$];
  int         m_out = 0;
  bit         m_err = 1'b0;

  always @(posedge clk) begin
    bit          can_issue, acc, hs;
    logic [31:0] s;
    res_t        e;
    if (reset) begin
      m_tags.delete();
      m_res.delete();
      m_out = 0;
      m_err = 1'b0;
    end else begin
      can_issue = (m_out < 4);
      acc = issue && can_issue;
      hs  = wb_ready && (m_res.size() != 0);
      if (issue && !can_issue) m_err = 1'b1;
      if (hs) void'(m_res.pop_front());
      if (mv) begin
        if (m_tags.size() == 0) begin
          m_err = 1'b1;
        end else begin
          s   = hi ? result[63:32] : result[31:0];
          e.r = m_tags.pop_front();
          e.d = s;
          e.f = {2'b00, s[31], (s == 32'd0)};
          m_res.push_back(e);
        end
      end
      if (acc) m_tags.push_back(reg_in);
      m_out = m_out + int'(acc) - int'(hs);
    end
  end

  task automatic idle_inputs;
    issue = 1'b0; mv = 1'b0; wb_ready = 1'b0; hi = 1'b0; result = '0; reg_in = '0;
  endtask

  task automatic apply_reset(input int n);
    idle_inputs();
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset(3);
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %b want 0", wb_valid); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready got %b want 1", issue_ready); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if ({wb_reg, wb_data, wb_flags} !== '0) begin errors++; $display("FAIL reset_lowpower_outputs got %h/%h/%h want 0", wb_reg, wb_data, wb_flags); end
    $display("test_reset done");
  endtask

  task automatic test_basic;
    apply_reset(1);
    issue = 1'b1; reg_in = 5'd3;
    @(negedge clk); issue = 1'b0;
    @(negedge clk);
    mv = 1'b1; result = 64'h0000_0002_0000_0005; hi = 1'b0;
    @(negedge clk); mv = 1'b0;
    checks++; if ({wb_valid, wb_reg, wb_data, wb_flags} !== {1'b1, 5'd3, 32'h5, 4'b0000}) begin
      errors++; $display("FAIL basic_lo got v=%b r=%0d d=%h f=%b want v=1 r=3 d=5 f=0000", wb_valid, wb_reg, wb_data, wb_flags); end
    wb_ready = 1'b1;
    @(negedge clk); wb_ready = 1'b0;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL basic_retired got %b want 0", wb_valid); end
    issue = 1'b1; reg_in = 5'd7;
    @(negedge clk);
    @(negedge clk); issue = 1'b0;
    mv = 1'b1; result = 64'h8000_0000_0000_0000; hi = 1'b1;
    @(negedge clk); hi = 1'b0;
    @(negedge clk); mv = 1'b0;
    checks++; if ({wb_valid, wb_reg, wb_data, wb_flags} !== {1'b1, 5'd7, 32'h8000_0000, 4'b0010}) begin
      errors++; $display("FAIL basic_neg got v=%b r=%0d d=%h f=%b want v=1 r=7 d=80000000 f=0010", wb_valid, wb_reg, wb_data, wb_flags); end
    wb_ready = 1'b1;
    @(negedge clk);
    checks++; if ({wb_valid, wb_reg, wb_data, wb_flags} !== {1'b1, 5'd7, 32'h0, 4'b0001}) begin
      errors++; $display("FAIL basic_zero got v=%b r=%0d d=%h f=%b want v=1 r=7 d=0 f=0001", wb_valid, wb_reg, wb_data, wb_flags); end
    @(negedge clk); wb_ready = 1'b0;
    checks++; if (wb_valid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL basic_end got v=%b e=%b want v=0 e=0", wb_valid, err); end
    $display("test_basic done");
  endtask

  task automatic test_back_to_back;
    apply_reset(1);
    for (int k = 0; k < 7; k++) begin
      if (k == 3) begin
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_before_4th got %b want 1", issue_ready); end
      end
      if (k == 4) begin
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_full got %b want 0", issue_ready); end
      end
      issue  = (k < 4);
      reg_in = 5'(k + 1);
      mv     = (k >= 2 && k < 6);
      result = {32'h0, 32'(k - 1)};
      hi     = 1'b0;
      @(negedge clk);
    end
    idle_inputs();
    checks++; if ({wb_valid, wb_reg} !== {1'b1, 5'd1}) begin errors++; $display("FAIL b2b_head got v=%b r=%0d want v=1 r=1", wb_valid, wb_reg); end
    // Handshake and issue together while full: the issue is refused.
    wb_ready = 1'b1; issue = 1'b1; reg_in = 5'd9;
    @(negedge clk); issue = 1'b0;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_return got %b want 1", issue_ready); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL b2b_overissue_err got %b want 1", err); end
    for (int k = 2; k <= 4; k++) begin
      checks++; if ({wb_valid, wb_reg, wb_data} !== {1'b1, 5'(k), 32'(k)}) begin
        errors++; $display("FAIL b2b_order got v=%b r=%0d d=%h want v=1 r=%0d d=%h", wb_valid, wb_reg, wb_data, k, k); end
      @(negedge clk);
    end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %b want 0", wb_valid); end
    $display("test_back_to_back done");
  endtask

  task automatic test_error;
    apply_reset(1);
    mv = 1'b1; result = 64'h1234;
    @(negedge clk); mv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if ({err, wb_valid} !== 2'b10) begin errors++; $display("FAIL err_sticky got e=%b v=%b want e=1 v=0", err, wb_valid); end
      @(negedge clk);
    end
    apply_reset(1);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_cleared got %b want 0", err); end
    $display("test_error done");
  endtask

  task automatic test_reset_mid;
    apply_reset(1);
    for (int k = 0; k < 4; k++) begin
      issue  = (k < 3);
      reg_in = 5'(k + 5);
      mv     = (k >= 1);
      result = 64'h55;
      @(negedge clk);
    end
    idle_inputs();
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL mid_buffered got %b want 1", wb_valid); end
    apply_reset(1);
    checks++; if ({wb_valid, issue_ready} !== 2'b01) begin errors++; $display("FAIL mid_after_reset got v=%b rdy=%b want v=0 rdy=1", wb_valid, issue_ready); end
    issue = 1'b1; reg_in = 5'd11;
    @(negedge clk); issue = 1'b0;
    @(negedge clk);
    mv = 1'b1; result = 64'h0000_0001_FFFF_FFFF; hi = 1'b1;
    @(negedge clk); mv = 1'b0;
    checks++; if ({wb_valid, wb_reg, wb_data, wb_flags} !== {1'b1, 5'd11, 32'h1, 4'b0000}) begin
      errors++; $display("FAIL mid_fresh got v=%b r=%0d d=%h f=%b want v=1 r=11 d=1 f=0000", wb_valid, wb_reg, wb_data, wb_flags); end
    wb_ready = 1'b1;
    @(negedge clk); wb_ready = 1'b0;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL mid_fresh_retired got %b want 0", wb_valid); end
    $display("test_reset_mid done");
  endtask

  task automatic test_random;
    res_t h;
    int   bad = 0;
    apply_reset(1);
    for (int k = 0; k < 3000; k++) begin
      h = (m_res.size() != 0) ? m_res[0] : '0;
      checks++;
      if (wb_valid !== (m_res.size() != 0) || issue_ready !== (m_out < 4) || err !== m_err ||
          {wb_reg, wb_data, wb_flags} !== {h.r, h.d, h.f}) begin
        errors++; bad++;
        if (bad <= 10)
          $display("FAIL random_cycle%0d got v=%b rdy=%b e=%b r=%0d d=%h f=%b want v=%b rdy=%b e=%b r=%0d d=%h f=%b",
                   k, wb_valid, issue_ready, err, wb_reg, wb_data, wb_flags,
                   m_res.size() != 0, m_out < 4, m_err, h.r, h.d, h.f);
      end
      issue    = (($urandom % 3) != 0) && ((m_out < 4) || (($urandom % 64) == 0));
      reg_in   = 5'($urandom);
      mv       = (m_tags.size() != 0) && (($urandom % 2) == 0);
      result   = {$urandom, $urandom};
      if (($urandom % 6) == 0) result[31:0] = '0;
      if (($urandom % 6) == 0) result[63:32] = '0;
      hi       = 1'($urandom);
      wb_ready = (($urandom % 4) != 0);
      @(negedge clk);
    end
    idle_inputs();
    $display("test_random done");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_error();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mpy_retire.md
Name: mpy_retire

Overview:
- Retire stage directly downstream of the CPU multiply unit.
- Captures the destination register tag at issue, pairs it with the multiplier's 64-bit product when that product emerges, and selects the low or high 32 bits.
- Computes N/Z flags and buffers completed results for the writeback port under a valid/ready handshake.
- Throttles issue so that no product is ever dropped; the multiplier has no backpressure.

Parameters:
- LGDEPTH, 2: log2 of maximum outstanding multiplies (issued but not yet written back).
- REGW, 5: destination register tag width.
- OPT_LOWPOWER, 1'b0: when 1, o_wb_data, o_wb_reg and o_wb_flags are forced to 0 whenever o_wb_valid=0.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset; synchronous, active-high
- i_issue  in  1  multiply issued this cycle (same strobe driven to the multiplier)
- i_reg  in  REGW  destination register of the issued multiply
- o_issue_ready  out  1  issue permitted this cycle
- i_mpy_valid  in  1  multiplier product valid
- i_mpy_result  in  64  multiplier product
- i_mpy_hi  in  1  1 selects bits [63:32], 0 selects bits [31:0]
- o_wb_valid  out  1  completed result available
- i_wb_ready  in  1  writeback accepts
- o_wb_reg  out  REGW  destination tag
- o_wb_data  out  32  selected result half
- o_wb_flags  out  4  {C,V,N,Z}
- o_err  out  1  sticky protocol error

Behaviour:
- Reset: o_wb_valid=0, o_err=0, outstanding=0, o_issue_ready=1, both FIFO pointers=0. o_wb_data, o_wb_reg and o_wb_flags read 0 under OPT_LOWPOWER, otherwise don't-care.
- Outstanding counter (LGDEPTH+1 bits):
  - +1 on accepted issue (i_issue && o_issue_ready).
  - -1 on writeback handshake (o_wb_valid && i_wb_ready).
  - Both events in the same cycle leave it unchanged.
- o_issue_ready = (outstanding < 2^LGDEPTH); combinational from the registered counter.
- Tag FIFO (depth 2^LGDEPTH):
  - Push i_reg on accepted issue.
  - Pop on i_mpy_valid.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full.
- Result FIFO (depth 2^LGDEPTH):
  - Push on i_mpy_valid the entry {tag head, sel, N, Z}.
  - sel = i_mpy_hi ? result[63:32] : result[31:0]; N = sel[31]; Z = (sel==0); C = V = 0.
  - Pop on writeback handshake.
- Latency: the first-word-fall-through head of the result FIFO is registered, so o_wb_valid rises the cycle after i_mpy_valid when the FIFO was empty.
- Throughput: 1 result per cycle. Results retire in strict issue order.
- Overflow is impossible by construction: tag count + result count <= outstanding <= 2^LGDEPTH.
- Protocol errors set o_err=1, which holds until reset:
  - i_issue=1 while o_issue_ready=0. The issue is ignored; no push, no count change.
  - i_mpy_valid=1 with the tag FIFO empty. The product is discarded; no push.
- i_wb_ready with o_wb_valid=0: no effect.
- o_wb_* hold stable while o_wb_valid && !i_wb_ready.
- Reset mid-operation: all buffered tags and results are discarded. Products arriving after reset are the multiplier's responsibility; that unit is reset on the same i_reset.

Decomposition:
- Shared CPU package holds:
  - Flag bit indices: FLAG_Z=0, FLAG_N=1, FLAG_V=2, FLAG_C=3.
  - The default register tag width.
- One natural sub-module: mpy_sfifo, a synchronous FIFO with parameters LGDEPTH and WIDTH.
  - Instantiated twice: tag FIFO (WIDTH=REGW) and result FIFO (WIDTH=REGW+34).
  - Its outputs are registered, with fall-through on empty.

Test Plan:
- Issue reg=3; 2 cycles later mpy_valid, result=64'h0000_0002_0000_0005, hi=0 -> next cycle wb_valid, reg=3, data=32'h5, flags=4'b0000.
- Issue reg=7; product 64'h8000_0000_0000_0000, hi=1 -> data=32'h8000_0000, flags N=1 (4'b0010). Same product with hi=0 -> data=0, flags Z=1 (4'b0001).
- Hold i_wb_ready=0; issue regs 1,2,3,4 back-to-back with products returning -> o_issue_ready drops after the 4th issue. Raise ready -> regs retire in order 1,2,3,4, one per cycle; o_issue_ready returns the cycle after the first handshake.
- Outstanding=4 while a writeback handshake and an issue occur in the same cycle -> issue not accepted, since ready was 0. Next cycle outstanding=3 and ready=1.
- i_mpy_valid with no outstanding issue -> o_err=1, no wb_valid; o_err stays 1 until i_reset, then 0.
- 3 results buffered, assert i_reset for 1 cycle -> next cycle wb_valid=0, o_issue_ready=1, and a fresh issue/product pair retires normally.
